// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state encoding, default width and counter sizing for the piso transmitter
package piso_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Counter width for an arbitrary word width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bit_down_counter.sv
// rtl/bit_down_counter.sv - loadable down counter with zero flag, shared by the piso transmitter and receiver
module bit_down_counter
    import piso_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - MSB-first parallel-in/serial-out transmitter with first/last framing strobes
// PISO_TX_PARITY_EN appends an even-parity bit as the final frame bit.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt;
    logic             cnt_zero;
    logic             cnt_load;
    logic             cnt_dec;
    logic             accept;
    logic             ser_out_n;
    logic             ser_first_n;
    logic             ser_last_n;

`ifdef PISO_TX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^in_data;
        end
    end
`endif

    bit_down_counter #(
        .W (CW)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (CNT_LOAD),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        accept      = 1'b0;
        ser_out_n   = 1'b0;
        ser_first_n = 1'b0;
        ser_last_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    accept      = 1'b1;
                    cnt_load    = 1'b1;
                    shreg_n     = in_data;
                    state_n     = ST_SHIFT;
                    ser_first_n = 1'b1;
                end
            end
            ST_SHIFT: begin
                cnt_dec = !cnt_zero;
                shreg_n = shreg << 1;
                if (cnt_zero) begin
`ifdef PISO_TX_PARITY_EN
                    state_n = ST_PARITY;
`else
                    state_n = ST_IDLE;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            ST_PARITY: state_n = ST_IDLE;
`endif
            default: state_n = ST_IDLE;
        endcase

        // Output flops are loaded with what the state being entered will present.
        if (state_n == ST_SHIFT) begin
            ser_out_n = shreg_n[WIDTH-1];
`ifndef PISO_TX_PARITY_EN
            ser_last_n = (state == ST_SHIFT) && (cnt == CNT_ONE);
`endif
        end
`ifdef PISO_TX_PARITY_EN
        if (state_n == ST_PARITY) begin
            ser_out_n  = par_q;
            ser_last_n = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            in_ready  <= 1'b0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            in_ready  <= (state_n == ST_IDLE);
            ser_out   <= ser_out_n;
            ser_valid <= (state_n != ST_IDLE);
            ser_first <= ser_first_n;
            ser_last  <= ser_last_n;
            busy      <= (state_n != ST_IDLE);
        end
    end

endmodule
